// File: rtl/ay_amplitude_mixer.sv
// rtl/ay_amplitude_mixer.sv - AY-style three-channel gate/volume mixer with sequential summing and PWM output
module ay_amplitude_mixer #(
    parameter int SAMPLE_BITS = 10,
    parameter int PWM_BITS    = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   strobe,
    input  logic                   tone_a,
    input  logic                   tone_b,
    input  logic                   tone_c,
    input  logic                   noise,
    input  logic [5:0]             mixer_ctrl,
    input  logic [4:0]             amp_a,
    input  logic [4:0]             amp_b,
    input  logic [4:0]             amp_c,
    input  logic [3:0]             envelope,
    output logic [SAMPLE_BITS-1:0] sample_out,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   pwm_out
);

    typedef enum logic [2:0] {IDLE, ACC_A, ACC_B, ACC_C, OUT} state_t;

    state_t state, state_next;

    logic [2:0]             s_tone;
    logic                   s_noise;
    logic [5:0]             s_mixer;
    logic [4:0]             s_amp_a, s_amp_b, s_amp_c;
    logic [3:0]             s_env;
    logic [SAMPLE_BITS-1:0] acc;

    logic                   ch_tone, ch_tdis, ch_ndis, ch_gate;
    logic [4:0]             ch_amp;
    logic [3:0]             ch_level;
    logic [SAMPLE_BITS-1:0] ch_contrib;

    logic [PWM_BITS-1:0]    pwm_cnt;
    logic [PWM_BITS-1:0]    pwm_level;

    // Logarithmic DAC curve: roughly 3 dB per step.
    function automatic logic [7:0] vol(input logic [3:0] lvl);
        case (lvl)
            4'd0:    vol = 8'd0;
            4'd1:    vol = 8'd2;
            4'd2:    vol = 8'd3;
            4'd3:    vol = 8'd4;
            4'd4:    vol = 8'd6;
            4'd5:    vol = 8'd8;
            4'd6:    vol = 8'd11;
            4'd7:    vol = 8'd16;
            4'd8:    vol = 8'd23;
            4'd9:    vol = 8'd32;
            4'd10:   vol = 8'd45;
            4'd11:   vol = 8'd64;
            4'd12:   vol = 8'd90;
            4'd13:   vol = 8'd128;
            4'd14:   vol = 8'd180;
            default: vol = 8'd255;
        endcase
    endfunction

    assign busy = (state != IDLE);

    // One shared gate/volume path, steered to the channel being accumulated.
    always_comb begin
        ch_tone = s_tone[0];
        ch_tdis = s_mixer[0];
        ch_ndis = s_mixer[3];
        ch_amp  = s_amp_a;
        case (state)
            ACC_B: begin
                ch_tone = s_tone[1];
                ch_tdis = s_mixer[1];
                ch_ndis = s_mixer[4];
                ch_amp  = s_amp_b;
            end
            ACC_C: begin
                ch_tone = s_tone[2];
                ch_tdis = s_mixer[2];
                ch_ndis = s_mixer[5];
                ch_amp  = s_amp_c;
            end
            default: ;
        endcase
        ch_level   = ch_amp[4] ? s_env : ch_amp[3:0];
        ch_gate    = (ch_tone | ch_tdis) & (s_noise | ch_ndis);
        ch_contrib = ch_gate ? {{(SAMPLE_BITS-8){1'b0}}, vol(ch_level)} : '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (strobe) state_next = ACC_A;
            ACC_A:   state_next = ACC_B;
            ACC_B:   state_next = ACC_C;
            ACC_C:   state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_next;
            sample_valid <= 1'b0;
            case (state)
                IDLE:  if (strobe) acc <= '0;
                ACC_A: acc <= ch_contrib;
                ACC_B,
                ACC_C: acc <= acc + ch_contrib;
                OUT: begin
                    sample_out   <= acc;
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Snapshot needs no reset: it is only read after being loaded on a strobe.
    always_ff @(posedge clk) begin
        if (state == IDLE && strobe) begin
            s_tone  <= {tone_c, tone_b, tone_a};
            s_noise <= noise;
            s_mixer <= mixer_ctrl;
            s_amp_a <= amp_a;
            s_amp_b <= amp_b;
            s_amp_c <= amp_c;
            s_env   <= envelope;
        end
    end

    // Duty reloads only at the wrap so a period is never split between two levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt   <= '0;
            pwm_level <= '0;
            pwm_out   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1)
                pwm_level <= sample_out[SAMPLE_BITS-1 -: PWM_BITS];
            pwm_out <= (pwm_cnt < pwm_level);
        end
    end

endmodule

// File: tb/tb_ay_amplitude_mixer.sv
// tb/tb_ay_amplitude_mixer.sv - self-checking bench for ay_amplitude_mixer
module tb_ay_amplitude_mixer;

    logic       clk = 1'b0;
    logic       reset, strobe;
    logic       tone_a, tone_b, tone_c, noise;
    logic [5:0] mixer_ctrl;
    logic [4:0] amp_a, amp_b, amp_c;
    logic [3:0] envelope;
    logic [9:0] sample_out;
    logic       sample_valid, busy, pwm_out;

    int errors = 0;
    int checks = 0;
    int vol_tbl [16] = '{0, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 180, 255};
    logic [9:0] pcnt;

    ay_amplitude_mixer #(.SAMPLE_BITS(10), .PWM_BITS(10)) dut (
        .clk(clk), .reset(reset), .strobe(strobe),
        .tone_a(tone_a), .tone_b(tone_b), .tone_c(tone_c), .noise(noise),
        .mixer_ctrl(mixer_ctrl), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
        .envelope(envelope), .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    // Free-running period position of the PWM, restarted by reset.
    always @(posedge clk) begin
        if (reset) pcnt <= '0;
        else       pcnt <= pcnt + 10'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input logic [2:0] t, input logic n, input logic [5:0] m,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [4:0] a2, input logic [3:0] e);
        logic [4:0] a [3];
        int sum = 0;
        a[0] = a0; a[1] = a1; a[2] = a2;
        for (int c = 0; c < 3; c++) begin
            if ((t[c] | m[c]) && (n | m[c+3]))
                sum += vol_tbl[a[c][4] ? e : a[c][3:0]];
        end
        return sum;
    endfunction

    task automatic randomize_inputs();
        {tone_c, tone_b, tone_a} = 3'($urandom);
        noise      = 1'($urandom);
        mixer_ctrl = 6'($urandom);
        amp_a      = 5'($urandom);
        amp_b      = 5'($urandom);
        amp_c      = 5'($urandom);
        envelope   = 4'($urandom);
    endtask

    task automatic convert(input int exp, input string tag, input bit scramble);
        int  lat = 0;
        bit  got = 0;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        if (scramble) randomize_inputs();
        for (int i = 1; i <= 10 && !got; i++) begin
            tick();
            if (sample_valid) begin
                got = 1;
                lat = i;
            end
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " sample"}, int'(sample_out), exp);
    endtask

    task automatic set_dc(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        {tone_c, tone_b, tone_a} = 3'b000;
        noise      = 1'b0;
        mixer_ctrl = 6'b111111;
        amp_a = a0; amp_b = a1; amp_c = a2;
        envelope = 4'd0;
    endtask

    initial begin
        int vcnt, last, high, wait_n, exp;
        reset = 1'b1; strobe = 1'b0;
        set_dc(5'h00, 5'h00, 5'h00);
        repeat (3) tick();
        reset = 1'b0;

        vcnt = 0;
        repeat (20) begin
            tick();
            if (sample_valid) vcnt++;
        end
        check("idle valid pulses", vcnt, 0);
        check("idle sample_out", int'(sample_out), 0);
        check("idle busy", int'(busy), 0);
        check("idle pwm_out", int'(pwm_out), 0);

        set_dc(5'h0F, 5'h0F, 5'h0F);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dc busy step %0d", i), int'(busy), 1);
            check($sformatf("dc early valid step %0d", i), int'(sample_valid), 0);
            tick();
        end
        check("dc valid", int'(sample_valid), 1);
        check("dc busy after", int'(busy), 0);
        check("dc sample", int'(sample_out), 765);
        tick();
        check("dc valid single cycle", int'(sample_valid), 0);

        mixer_ctrl = 6'b000000; tone_a = 1'b1; noise = 1'b0;
        amp_a = 5'h0F; amp_b = 5'h00; amp_c = 5'h00;
        convert(0, "gate noise low", 0);
        noise = 1'b1;
        convert(255, "gate both high", 0);
        tone_a = 1'b0;
        convert(0, "gate tone low", 0);

        set_dc(5'h10, 5'h00, 5'h00);
        for (int e = 0; e < 16; e++) begin
            envelope = 4'(e);
            convert(vol_tbl[e], $sformatf("env %0d", e), 0);
        end
        set_dc(5'h10, 5'h00, 5'h00);
        envelope = 4'd5;
        convert(vol_tbl[5], "env capture", 1);

        for (int r = 0; r < 40; r++) begin
            randomize_inputs();
            exp = model({tone_c, tone_b, tone_a}, noise, mixer_ctrl, amp_a, amp_b, amp_c, envelope);
            convert(exp, $sformatf("rand %0d", r), 1);
        end

        set_dc(5'h0F, 5'h0C, 5'h00);
        strobe = 1'b1;
        vcnt = 0; last = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sample_valid) begin
                vcnt++;
                if (last >= 0) check("stream spacing", i - last, 5);
                check("stream sample", int'(sample_out), 255 + 90);
                last = i;
            end
        end
        strobe = 1'b0;
        check("stream pulse count", vcnt, 8);
        repeat (6) tick();

        reset = 1'b1; tick(); reset = 1'b0;
        set_dc(5'h0F, 5'h0F, 5'h0F);
        strobe = 1'b1; tick(); strobe = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        vcnt = 0;
        repeat (8) begin
            tick();
            if (sample_valid) vcnt++;
        end
        check("abort valid pulses", vcnt, 0);
        check("abort sample_out", int'(sample_out), 0);
        check("abort busy", int'(busy), 0);

        set_dc(5'h0F, 5'h0F, 5'h01);
        convert(512, "pwm setup", 0);
        tick();
        wait_n = 0;
        while (pcnt != 10'd0 && wait_n < 2048) begin
            tick();
            wait_n++;
        end
        check("pwm wrap found", int'(pcnt), 0);
        high = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i == 300) begin
                amp_c = 5'h00;
                strobe = 1'b1;
            end
            if (i == 301) strobe = 1'b0;
            tick();
            if (pwm_out) high++;
        end
        check("pwm duty 512 held mid-period", high, 512);
        check("pwm new sample", int'(sample_out), 510);
        high = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (pwm_out) high++;
        end
        check("pwm duty next period", high, 510);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
